// File: rtl/pipelined_cla_addsub_if.sv
// pipelined_cla_addsub_if: operand/result handshake bundle for pipelined_cla_addsub (sat present with CLA_SATURATE_EN)
interface pipelined_cla_addsub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
`ifdef CLA_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;
  modport master (
`ifdef CLA_SATURATE_EN
    output sat,
`endif
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );
  modport slave (
`ifdef CLA_SATURATE_EN
    input  sat,
`endif
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit add/sub, one GROUP-bit lookahead group per stage, valid/ready handshake.
// Optional saturation on signed overflow when CLA_SATURATE_EN is defined.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic clk,
  input logic rst,
  pipelined_cla_addsub_if.slave bus
);
  localparam int NG = WIDTH / GROUP;
  if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of GROUP");
  end
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] g, input logic [GROUP-1:0] p, input logic ci);
    logic [GROUP:0] c;
    logic t;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      t = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (t & g[j]);
        t = t & p[j];
      end
      c[i+1] = c[i+1] | (t & ci);
    end
    return c;
  endfunction
  logic             adv;
  logic             st_v  [NG];
  logic [WIDTH-1:0] st_a  [NG];
  logic [WIDTH-1:0] st_bx [NG];
  logic [WIDTH-1:0] st_s  [NG];
  logic             st_c  [NG];
`ifdef CLA_SATURATE_EN
  logic             st_sat [NG];
`endif
  logic [GROUP-1:0] gs  [NG];
  logic             gco [NG];
  logic             gcm [NG];
  logic             out_valid_r, c_out_r, ovf_r, zero_r;
  logic [WIDTH-1:0] sum_r, raw, res;
  logic             co, ov;
  assign adv          = !out_valid_r || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_r;
  assign bus.sum      = sum_r;
  assign bus.c_out    = c_out_r;
  assign bus.ovf      = ovf_r;
  assign bus.zero     = zero_r;
  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [GROUP-1:0] ga, gb, gp;
    logic [GROUP:0]   gc;
    assign ga     = st_a[k][k*GROUP +: GROUP];
    assign gb     = st_bx[k][k*GROUP +: GROUP];
    assign gp     = ga ^ gb;
    assign gc     = lookahead(ga & gb, gp, st_c[k]);
    assign gs[k]  = gp ^ gc[GROUP-1:0];
    assign gco[k] = gc[GROUP];
    assign gcm[k] = gc[GROUP-1];
  end
  assign raw = st_s[NG-1] | (WIDTH'(gs[NG-1]) << ((NG-1) * GROUP));
  assign co  = gco[NG-1];
  assign ov  = gcm[NG-1] ^ co;
`ifdef CLA_SATURATE_EN
  // on overflow the wrapped MSB is the inverse of the true sign
  assign res = (st_sat[NG-1] && ov) ? (raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}}) : raw;
`else
  assign res = raw;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) st_v[k] <= 1'b0;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else if (adv) begin
      st_v[0]  <= bus.in_valid;
      st_a[0]  <= bus.a;
      st_bx[0] <= bus.sub ? ~bus.b : bus.b;
      st_c[0]  <= bus.sub ? ~bus.c_in : bus.c_in;
      st_s[0]  <= '0;
`ifdef CLA_SATURATE_EN
      st_sat[0] <= bus.sat;
`endif
      for (int k = 0; k < NG - 1; k++) begin
        st_v[k+1]  <= st_v[k];
        st_a[k+1]  <= st_a[k];
        st_bx[k+1] <= st_bx[k];
        st_c[k+1]  <= gco[k];
        st_s[k+1]  <= st_s[k] | (WIDTH'(gs[k]) << (k * GROUP));
`ifdef CLA_SATURATE_EN
        st_sat[k+1] <= st_sat[k];
`endif
      end
      out_valid_r <= st_v[NG-1];
      sum_r       <= res;
      c_out_r     <= co;
      ovf_r       <= ov;
      zero_r      <= (res == '0);
    end
  end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: randomized + directed scoreboard bench for pipelined_cla_addsub (WIDTH=16, GROUP=4).
module tb_pipelined_cla_addsub;
  localparam int W = 16;
  localparam int LAT = 4;
`ifdef CLA_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] sum;
    logic c, v, z;
    int acc;
    bit lat;
  } exp_t;
  logic clk = 0, rst = 1;
  int checks = 0, errs = 0, cyc = 0;
  exp_t q[$];
  bit held = 0, done = 0;
  logic [W-1:0] h_sum;
  logic h_c, h_v, h_z;
  pipelined_cla_addsub_if #(.WIDTH(W)) bus ();
  pipelined_cla_addsub #(.WIDTH(W), .GROUP(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s, input logic st);
    exp_t e;
    longint ua, ub, sa, sb, u, t;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    u = s ? ua - ub - c : ua + ub + c;
    t = s ? sa - sb - c : sa + sb + c;
    e.c = s ? (u >= 0) : (u > 65535);
    e.v = (t > 32767) || (t < -32768);
    e.sum = u[W-1:0];
    if (SAT && st && e.v) e.sum = (t > 0) ? 16'h7fff : 16'h8000;
    e.z = (e.sum == 0);
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction
  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [4] = '{16'h0000, 16'hffff, 16'h7fff, 16'h8000};
    return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
  endfunction
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s, input logic st, input bit lat);
    int n = 0;
    exp_t e;
    bus.in_valid = 1; bus.a = a; bus.b = b; bus.c_in = c; bus.sub = s;
`ifdef CLA_SATURATE_EN
    bus.sat = st;
`endif
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errs++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end else begin
      e = model(a, b, c, s, st);
      e.acc = cyc + 1;
      e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask
  task automatic do_reset();
    rst = 1; bus.in_valid = 0;
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.c_out !== 1'b0 || bus.ovf !== 1'b0 || bus.zero !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: out_valid=%b sum=%h c=%b v=%b z=%b required all 0", bus.out_valid, bus.sum, bus.c_out, bus.ovf, bus.zero);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
  endtask
  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (held) begin
        checks++;
        if (!bus.out_valid || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== {h_sum, h_c, h_v, h_z}) begin
          errs++;
          $display("FAIL hold: out_valid=%b sum=%h c=%b v=%b z=%b required 1 %h %b %b %b", bus.out_valid, bus.sum, bus.c_out, bus.ovf, bus.zero, h_sum, h_c, h_v, h_z);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      {h_sum, h_c, h_v, h_z} = {bus.sum, bus.c_out, bus.ovf, bus.zero};
      if (held) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errs++;
          $display("FAIL stall_in_ready: in_ready=%b required 0", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_result: sum=%h with empty scoreboard", bus.sum);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({bus.sum, bus.c_out, bus.ovf, bus.zero} !== {e.sum, e.c, e.v, e.z}) begin
            errs++;
            $display("FAIL result: sum=%h c=%b v=%b z=%b required %h %b %b %b", bus.sum, bus.c_out, bus.ovf, bus.zero, e.sum, e.c, e.v, e.z);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.acc != LAT) begin
              errs++;
              $display("FAIL latency: got %0d required %0d", cyc - e.acc, LAT);
            end
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.c_in = 0; bus.sub = 0; bus.out_ready = 1;
`ifdef CLA_SATURATE_EN
    bus.sat = 0;
`endif
    @(posedge clk); #1;
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", bus.in_ready);
    end
    send(16'h1234, 16'h1111, 0, 0, 0, 1); drain();
    send(16'hffff, 16'h0000, 1, 0, 0, 1); drain();
    send(16'h7fff, 16'h0001, 0, 0, 0, 1); drain();
    send(16'h0005, 16'h0007, 0, 1, 0, 1); drain();
    send(16'h8000, 16'h0001, 0, 1, 0, 1); drain();
    send(16'h0000, 16'h0001, 0, 1, 0, 1); drain();
    send(16'hffff, 16'h0001, 0, 0, 0, 1); drain();
    fork
      for (int i = 0; i < 6; i++) send(16'h0100 * i[15:0], 16'h0011, 0, 0, 0, 0);
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(pick(), pick(), 0, 0, 0, 0);
    do_reset();
    send(16'h0001, 16'h0001, 0, 0, 0, 1); drain();
`ifdef CLA_SATURATE_EN
    send(16'h7fff, 16'h0001, 0, 0, 1, 1);
    send(16'h8000, 16'h0001, 0, 1, 1, 1);
    send(16'h8000, 16'h8000, 0, 0, 1, 1);
    drain();
`endif
    for (int i = 0; i < 40; i++) begin
      send(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    fork
      begin
        for (int i = 0; i < 60; i++) send(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        done = 1;
      end
      while (!done) begin
        @(posedge clk); #1;
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    bus.out_ready = 1;
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised successor to the team's 4-bit carry-lookahead adder: WIDTH-bit adder/subtractor built from GROUP-bit lookahead groups, with one group evaluated per pipeline stage.
- Adds subtract mode, carry/overflow/zero flags and a valid/ready handshake with back-pressure.
- Sits in the ALU datapath between the operand register file and the result writeback stage.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of GROUP; otherwise elaboration fails via a generate-time error.
- GROUP, 4: bits per carry-lookahead group. Each group forms one pipeline stage.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = a+b+c_in; 1 = a-b-c_in
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result
- c_out  output  1  carry-out (add); NOT borrow (sub)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (clk edge with rst=1) clears:
  - all stage valid bits;
  - out_valid, sum, c_out, ovf, zero to 0.
  - rst dominates in_valid on the same cycle. In-flight beats are discarded and never emerge.
- NG = WIDTH/GROUP stages, with stage k handling bits [k*GROUP +: GROUP].
- Operand preparation on accept:
  - bx = sub ? ~b : b
  - cx = sub ? ~c_in : c_in
- Group lookahead, per bit:
  - g = a & bx
  - p = a ^ bx
  - carries c[i+1] = g[i] | (p[i] & c[i]), fully flattened within the group
  - s = p ^ c
- Stage k takes the group carry registered by stage k-1; stage 0 uses cx.
- Unprocessed upper operand bits and already-computed lower sum bits travel with the beat in pipeline registers.
- Latency: exactly NG cycles from the accept edge to out_valid=1 when there is no stall. Throughput is one beat per cycle.
- Flags are computed in the final stage and registered with sum:
  - c_out = carry out of bit WIDTH-1
  - ovf = carry into MSB XOR carry out of MSB
  - zero = (sum == 0)
- Handshake:
  - advance = !out_valid | out_ready
  - in_ready = advance (combinational)
  - A beat is accepted when in_valid & in_ready.
  - When advance=0 the whole pipeline holds, and outputs stay stable until taken.
  - A bubble (in_valid=0 while advancing) propagates as valid=0.
  - The output beat transfers on out_valid & out_ready. Simultaneous transfer and accept in one cycle is legal and loses nothing.
- out_valid may not drop without a transfer. sum and flags must not change while out_valid=1 and out_ready=0.
- Wrap-around: results are modulo 2^WIDTH. Examples: 0xFFFF+1 gives sum 0, c_out=1, zero=1; 0-1 gives 0xFFFF, c_out=0.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- Defined:
  - adds input `sat` (1 bit), sampled with the operands and carried down the pipeline;
  - when sat=1 and ovf=1, sum clamps to 0x7FFF..F if the true result was positive, or 0x800..0 if negative;
  - ovf still reports 1 and zero is evaluated on the clamped value;
  - latency is unchanged.
- Undefined: the port is absent and the result always wraps.

Test Plan (WIDTH=16, GROUP=4, latency 4):
- Reset then add: a=0x1234, b=0x1111, c_in=0, sub=0, out_ready=1 -> after 4 cycles sum=0x2345, c_out=0, ovf=0, zero=0; in_ready=1 throughout.
- Carry ripple across groups: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, c_out=0.
- Subtract: a=0x0005, b=0x0007, sub=1, c_in=0 -> sum=0xFFFE, c_out=0 (borrow). Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, c_out=1.
- Back-to-back and back-pressure:
  - Send 6 beats on consecutive cycles with out_ready=0 from cycle 5 for 3 cycles.
  - Required: in_ready=0 while stalled, first result held stable, all 6 results emerge in order with no loss or duplicates.
- Reset mid-flight: 3 beats in pipeline, rst=1 for one cycle -> out_valid=0 the next cycle; none of the 3 results ever appear; a new beat 1+1 yields sum=2 after 4 cycles.
- With CLA_SATURATE_EN: sat=1, a=0x7FFF, b=0x0001 -> sum=0x7FFF, ovf=1. Then sat=1, a=0x8000, b=0x0001, sub=1 -> sum=0x8000, ovf=1.
